tlp_eth_framer: RTL and testbench
=================================

# tlp_eth_framer

Converts captured PCIe TLPs, read from the CDC FIFO (`pcie2eth_fifo`) in the 156.25 MHz domain, into Ethernet frames for the 10G MAC TX AXI-Stream port. Each frame is built as follows:

- a 14-byte Ethernet header, followed by a 2-byte sequence field;
- the TLP words, passed through unchanged;
- zero padding up to the 60-byte minimum frame size, where needed.

Oversize TLPs are truncated and aborted, and the remainder is drained from the FIFO. Three counters expose frame, truncation and underrun statistics.

## Interface
Parameters:
- `ETHERTYPE`, 16'h88B5: EtherType placed in header bytes 12–13.
- `MAX_PAYLOAD_WORDS`, 160: maximum number of TLP words per frame; words beyond this are truncated.

Ports:
- `clk156`  in  1  core clock (MAC `coreclk_out`). One clock only.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `dst_mac`  in  48  destination MAC address; quasi-static, sampled in HDR0.
- `src_mac`  in  48  source MAC address; quasi-static, sampled in HDR0.
- `dout`  in  74  FIFO first-word-fall-through word. Fields:
  - [63:0] data
  - [71:64] keep
  - [72] reserved (ignored)
  - [73] last
- `empty`  in  1  FIFO empty.
- `rd_en`  out  1  FIFO pop, combinational.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tdata`[63:0], `m_axis_tkeep`[7:0], `m_axis_tlast`, `m_axis_tuser`: AXIS master to the MAC; `m_axis_tready` is the only input in this group.
- `frame_cnt`  out  32  number of frames completed.
- `trunc_cnt`  out  16  number of frames truncated.
- `underrun_cnt`  out  16  number of mid-frame cycles with the FIFO empty.

## Operation
Byte order and data rules:
- Byte n of a beat is `tdata`[8n+7:8n]; network byte order applies.
- Incoming keep is DW-granular: only 0x0F and 0xFF are legal.

Frame layout:
- Header beat 0: bytes 0–5 = `dst_mac`[47:0], MSB first; bytes 6–7 = `src_mac`[47:32].
- Header beat 1: bytes 0–3 = `src_mac`[31:0]; bytes 4–5 = `ETHERTYPE`; bytes 6–7 = `seq`[15:0], big-endian.
- Header beats always carry keep 0xFF.

States:
- IDLE → HDR0 when `!empty`.
- HDR0 → HDR1 → PAYLOAD, each step taken when the output slot is free.
- PAYLOAD: pop and forward one word per free slot. The output beat index is kept in `wcnt`, which includes the 2 header beats.
  - FIFO `last` with `wcnt`+1 ≥ 8: emit `tlast` → IDLE.
  - If `wcnt`+1 == 8 and keep is 0x0F: emit keep 0x0F (60 bytes). No extension is needed.
  - FIFO `last` with `wcnt`+1 < 8: emit the word with keep forced to 0xFF and the unused bytes zeroed → PAD.
  - Payload word count reaches `MAX_PAYLOAD_WORDS` without `last`: emit `tlast`=1, `tuser`=1 (MAC abort), increment `trunc_cnt` → DRAIN.
- PAD: emit zero beats with keep 0xFF until beat 7. Beat 7 carries keep 0x0F and `tlast` → IDLE.
- DRAIN: pop while `!empty` with no output; on a popped `last` → IDLE.

Pop and output rules:
- Slot free = `!m_axis_tvalid || m_axis_tready`.
- `rd_en` = `!empty` && ((PAYLOAD && slot free) || DRAIN).
- An empty FIFO in PAYLOAD produces no beat and increments `underrun_cnt` once per cycle.

Counters and sequence:
- `frame_cnt` increments on each accepted `tlast` beat, including aborted frames.
- `seq` increments at the same point and wraps at 16 bits.
- `frame_cnt`, `trunc_cnt` and `underrun_cnt` saturate at all-ones.

## Timing
- Reset values (asynchronous assertion): every output 0, state IDLE, `seq` 0, all counters 0.
- The output is a single registered beat: it loads when the slot is free and holds stable while `tvalid && !tready`.
- Latency from `empty` falling in IDLE to the first header beat valid: 2 cycles.
- FIFO word to its beat valid: 1 cycle.
- Throughput: 1 beat per cycle under continuous `tready`.
- Back-to-back frames: IDLE costs 1 bubble cycle between frames.
- Reset mid-frame: the frame is cut with no `tlast`. This is acceptable because the MAC is reset together with this block.
- `m_axis_tready` low while the FIFO has data: no pop and no underrun count.

## Configuration
- `TLP_FRAMER_SEQ_EN` defined: the `seq` register exists and header bytes 14–15 carry it.
- `TLP_FRAMER_SEQ_EN` undefined: bytes 14–15 are 0 and no `seq` flops are built.
- All other behaviour is identical in both builds.

## Structure
Package `eth_pkg` holds:
- `fifo_word_t`: packed struct with fields `last`, `rsvd`, `keep`, `data`.
- `framer_state_t`: enum IDLE, HDR0, HDR1, PAYLOAD, PAD, DRAIN.
- Constants `ETH_HDR_WORDS`=2, `MIN_FRAME_WORDS`=8, `MIN_LAST_KEEP`=8'h0F.

Sub-module `axis_out_reg`: the single-beat AXIS output register with slot-free logic. All other logic lives in the top module.

## Test plan
- One 3-DW TLP (2 words, keep 0xFF / 0x0F, `last`) with `dst` = 02:00:00:00:00:01 → 8 beats:
  - beat 0 bytes 0–5 = 02 00 00 00 00 01;
  - beat 1 bytes 4–5 = 88 B5;
  - beat 3 keep 0xFF with bytes 4–7 zero;
  - beats 4–6 zero;
  - beat 7 keep 0x0F with `tlast`.
- A 12-word TLP → 14 beats; last beat keep as input; no padding; `frame_cnt`=1.
- A 200-word TLP with `MAX_PAYLOAD_WORDS`=160 → beat 161 has `tlast`=`tuser`=1; 40 words are drained; `trunc_cnt`=1; the next frame is clean.
- Random `tready` (50%) over 100 TLPs → payload matches the FIFO byte-for-byte; `seq` runs 0..99; beats hold while stalled.
- FIFO empty for 5 cycles mid-TLP → `underrun_cnt`=5, the frame completes intact, and no extra beats appear.
- `sys_rst_n` asserted mid-frame → all outputs 0 immediately; after release, the next frame has `seq`=0.

Source files
------------

// File: rtl/tlp_eth_framer_pkg.sv
// Shared types, frame constants and header byte helper for the TLP framer.
// Used by both the default build and the TLP_FRAMER_SEQ_EN build.
package eth_pkg;

    typedef struct packed {
        logic       last;
        logic       rsvd;
        logic [7:0] keep;
        logic [63:0] data;
    } fifo_word_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        PAYLOAD = 3'd3,
        PAD     = 3'd4,
        DRAIN   = 3'd5
    } framer_state_t;

    localparam int ETH_HDR_WORDS = 2;
    localparam int MIN_FRAME_WORDS = 8;
    localparam logic [7:0] MIN_LAST_KEEP = 8'h0F;

    // Big-endian value to wire order: MSB byte lands in byte lane 0.
    function automatic logic [63:0] be64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = v[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tlp_eth_framer_if.sv
// AXI-Stream beat bundle between the framer and the 10G MAC TX port.
interface tlp_eth_framer_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/tlp_eth_framer_axis_out_reg.sv
// Single-beat registered AXIS output stage; holds while stalled.
module axis_out_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] data,
    input  logic [7:0]  keep,
    input  logic        last,
    input  logic        user,
    output logic        slot_free,
    tlp_eth_framer_if.master m_axis
);

    assign slot_free = !m_axis.tvalid || m_axis.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end else if (load) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= data;
            m_axis.tkeep  <= keep;
            m_axis.tlast  <= last;
            m_axis.tuser  <= user;
        end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/tlp_eth_framer.sv
// Frames FIFO TLP words into Ethernet frames for the 10G MAC TX port.
// Define TLP_FRAMER_SEQ_EN to carry a frame sequence number in bytes 14-15.
module tlp_eth_framer
    import eth_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int MAX_PAYLOAD_WORDS = 160
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  fifo_word_t  dout,
    input  logic        empty,
    output logic        rd_en,
    tlp_eth_framer_if.master m_axis,
    output logic [31:0] frame_cnt,
    output logic [15:0] trunc_cnt,
    output logic [15:0] underrun_cnt
);

    localparam int WW =
        $clog2(MAX_PAYLOAD_WORDS + ETH_HDR_WORDS + 1);
    localparam logic [WW-1:0] LAST_MIN =
        WW'(MIN_FRAME_WORDS - 1);
    localparam logic [WW-1:0] TRUNC_AT =
        WW'(MAX_PAYLOAD_WORDS + ETH_HDR_WORDS - 1);

    framer_state_t state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [31:0]   src_lo;
    logic [15:0]   seq;
    logic          slot_free;
    logic          load;
    logic [63:0]   ld_data;
    logic [7:0]    ld_keep;
    logic          ld_last;
    logic          ld_user;
    logic          trunc_hit;
    logic          underrun;
    logic          acc_last;
    logic          unused_rsvd;

    assign unused_rsvd = dout.rsvd;
    assign acc_last = m_axis.tvalid && m_axis.tready
                      && m_axis.tlast;
    assign underrun = (state == PAYLOAD) && empty;
    assign rd_en = !empty
        && (((state == PAYLOAD) && slot_free)
            || (state == DRAIN));

    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        load      = 1'b0;
        ld_data   = '0;
        ld_keep   = 8'hFF;
        ld_last   = 1'b0;
        ld_user   = 1'b0;
        trunc_hit = 1'b0;
        unique case (state)
            IDLE: begin
                wcnt_n = '0;
                if (!empty) state_n = HDR0;
            end
            HDR0: if (slot_free) begin
                load    = 1'b1;
                ld_data = be64({dst_mac, src_mac[47:32]});
                wcnt_n  = WW'(1);
                state_n = HDR1;
            end
            HDR1: if (slot_free) begin
                load    = 1'b1;
                ld_data = be64({src_lo, ETHERTYPE, seq});
                wcnt_n  = WW'(ETH_HDR_WORDS);
                state_n = PAYLOAD;
            end
            PAYLOAD: if (slot_free && !empty) begin
                load    = 1'b1;
                ld_data = dout.data;
                ld_keep = dout.keep;
                if (dout.last) begin
                    if (wcnt >= LAST_MIN) begin
                        ld_last = 1'b1;
                        state_n = IDLE;
                    end else begin
                        // Short frame: widen to a full beat, pad follows.
                        if (dout.keep == MIN_LAST_KEEP)
                            ld_data[63:32] = '0;
                        ld_keep = 8'hFF;
                        wcnt_n  = wcnt + WW'(1);
                        state_n = PAD;
                    end
                end else if (wcnt == TRUNC_AT) begin
                    ld_last   = 1'b1;
                    ld_user   = 1'b1;
                    trunc_hit = 1'b1;
                    state_n   = DRAIN;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            PAD: if (slot_free) begin
                load = 1'b1;
                if (wcnt == LAST_MIN) begin
                    ld_keep = MIN_LAST_KEEP;
                    ld_last = 1'b1;
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            DRAIN: if (!empty && dout.last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            wcnt   <= '0;
            src_lo <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if ((state == HDR0) && slot_free)
                src_lo <= src_mac[31:0];
        end
    end

`ifdef TLP_FRAMER_SEQ_EN
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) seq <= '0;
        else if (acc_last) seq <= seq + 16'd1;
    end
`else
    assign seq = '0;
`endif

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt    <= '0;
            trunc_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            if (acc_last && (frame_cnt != '1))
                frame_cnt <= frame_cnt + 32'd1;
            if (trunc_hit && (trunc_cnt != '1))
                trunc_cnt <= trunc_cnt + 16'd1;
            if (underrun && (underrun_cnt != '1))
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    axis_out_reg u_out (
        .clk       (clk156),
        .rst_n     (sys_rst_n),
        .load      (load),
        .data      (ld_data),
        .keep      (ld_keep),
        .last      (ld_last),
        .user      (ld_user),
        .slot_free (slot_free),
        .m_axis    (m_axis)
    );

endmodule

// File: tb/tb_tlp_eth_framer.sv
// Self-checking bench for tlp_eth_framer: vector table, corner sequences
// and randomized traffic against a byte-level frame model.
module tb_tlp_eth_framer;

    localparam int MAXW = 160;
    localparam int BUDGET = 20000;

    typedef logic [73:0] word_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;
    typedef struct {
        int         nw;
        logic [7:0] lk;
        int         nbeats;
        logic [7:0] keep;
        logic       user;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] dst;
    logic [47:0] src;
    logic [73:0] dout;
    logic        empty;
    logic        rd_en;
    logic        tready;
    logic [31:0] frame_cnt;
    logic [15:0] trunc_cnt;
    logic [15:0] underrun_cnt;

    tlp_eth_framer_if m_axis();
    assign m_axis.tready = tready;

    tlp_eth_framer #(
        .ETHERTYPE         (16'h88B5),
        .MAX_PAYLOAD_WORDS (MAXW)
    ) dut (
        .clk156       (clk),
        .sys_rst_n    (rst_n),
        .dst_mac      (dst),
        .src_mac      (src),
        .dout         (dout),
        .empty        (empty),
        .rd_en        (rd_en),
        .m_axis       (m_axis),
        .frame_cnt    (frame_cnt),
        .trunc_cnt    (trunc_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    word_t fifo[$];
    word_t tlp[$];
    beat_t got[$];
    beat_t expq[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_frames = 0;
    int    exp_trunc = 0;
    logic [15:0] exp_seq = 16'h0;
    bit    rand_ready = 1'b0;
    bit    stalled = 1'b0;
    beat_t held;

    // Output monitor: collects accepted beats, checks stall stability.
    always @(negedge clk) begin
        beat_t cur;
        cur = {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser};
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!m_axis.tvalid || cur !== held) begin
                    errors++;
                    $display("FAIL hold: tvalid=%b beat=%h required %h",
                             m_axis.tvalid, cur, held);
                end
            end
            if (m_axis.tvalid && tready) got.push_back(cur);
            stalled = m_axis.tvalid && !tready;
            held = cur;
        end
    end

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic void fifo_sync();
        empty = (fifo.size() == 0);
        dout = empty ? '0 : fifo[0];
    endfunction

    task automatic step();
        logic p;
        @(negedge clk);
        p = rd_en;
        @(posedge clk);
        #1;
        if (p && fifo.size() > 0) void'(fifo.pop_front());
        if (rand_ready) tready = ($urandom_range(0, 1) == 1);
        fifo_sync();
    endtask

    function automatic void make_tlp(input int n, input logic [7:0] lk);
        word_t w;
        tlp.delete();
        for (int i = 0; i < n; i++) begin
            w[63:0]  = {$urandom, $urandom};
            w[71:64] = (i == n - 1) ? lk : 8'hFF;
            w[72]    = ($urandom_range(0, 1) == 1);
            w[73]    = (i == n - 1);
            tlp.push_back(w);
        end
    endfunction

    function automatic void push_tlp();
        foreach (tlp[i]) fifo.push_back(tlp[i]);
        fifo_sync();
    endfunction

    // Expected frame built from the frame layout rules as bytes.
    function automatic void model_frame();
        logic [7:0]  hdr [16];
        logic [15:0] sq;
        beat_t       b;
        int          n;
`ifdef TLP_FRAMER_SEQ_EN
        sq = exp_seq;
`else
        sq = 16'h0;
`endif
        for (int i = 0; i < 6; i++) begin
            hdr[i]     = dst[47 - 8*i -: 8];
            hdr[6 + i] = src[47 - 8*i -: 8];
        end
        hdr[12] = 8'h88;
        hdr[13] = 8'hB5;
        hdr[14] = sq[15:8];
        hdr[15] = sq[7:0];
        for (int k = 0; k < 2; k++) begin
            b = '0;
            b.keep = 8'hFF;
            for (int j = 0; j < 8; j++) b.data[8*j +: 8] = hdr[8*k + j];
            expq.push_back(b);
        end
        n = (tlp.size() > MAXW) ? MAXW : tlp.size();
        for (int i = 0; i < n; i++) begin
            b = '0;
            b.data = tlp[i][63:0];
            b.keep = tlp[i][71:64];
            if (i == n - 1) begin
                if (tlp.size() > MAXW) begin
                    b.last = 1'b1;
                    b.user = 1'b1;
                    exp_trunc++;
                end else if (n + 2 >= 8) begin
                    b.last = 1'b1;
                end else begin
                    if (b.keep == 8'h0F) b.data[63:32] = '0;
                    b.keep = 8'hFF;
                end
            end
            expq.push_back(b);
        end
        for (int k = n + 2; k < 8; k++) begin
            b = '0;
            b.keep = (k == 7) ? 8'h0F : 8'hFF;
            b.last = (k == 7);
            expq.push_back(b);
        end
        exp_frames++;
        exp_seq++;
    endfunction

    task automatic run_frames(input string name);
        int cyc;
        cyc = 0;
        while ((got.size() < expq.size() || fifo.size() != 0)
               && cyc < BUDGET) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc >= BUDGET) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats, required %0d",
                     name, got.size(), expq.size());
        end
        repeat (4) step();
    endtask

    task automatic check_frames(input string name);
        checks++;
        if (got.size() != expq.size()) begin
            errors++;
            $display("FAIL %s beat count: got %0d required %0d",
                     name, got.size(), expq.size());
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                errors++;
                $display("FAIL %s beat %0d: got %h required %h",
                         name, i, got[i], expq[i]);
            end
        end
    endtask

    function automatic void clear_frames();
        got.delete();
        expq.delete();
    endfunction

    initial begin
        vec_t        vt [10];
        logic [15:0] ur0;
        logic [7:0]  lk;
        int          cyc;

        vt[0] = '{2,   8'h0F, 8,   8'h0F, 1'b0};
        vt[1] = '{12,  8'hFF, 14,  8'hFF, 1'b0};
        vt[2] = '{200, 8'h0F, 162, 8'hFF, 1'b1};
        vt[3] = '{12,  8'h0F, 14,  8'h0F, 1'b0};
        vt[4] = '{1,   8'hFF, 8,   8'h0F, 1'b0};
        vt[5] = '{5,   8'h0F, 8,   8'h0F, 1'b0};
        vt[6] = '{6,   8'h0F, 8,   8'h0F, 1'b0};
        vt[7] = '{6,   8'hFF, 8,   8'hFF, 1'b0};
        vt[8] = '{161, 8'hFF, 162, 8'hFF, 1'b1};
        vt[9] = '{160, 8'h0F, 162, 8'h0F, 1'b0};

        tready = 1'b1;
        dst = 48'h02_00_00_00_00_01;
        src = 48'h0A_0B_0C_0D_0E_0F;
        fifo_sync();
        #12;
        check("reset tdata", m_axis.tdata, 64'h0);
        check("reset ctrl", {m_axis.tvalid, m_axis.tkeep, m_axis.tlast,
                             m_axis.tuser, rd_en}, 64'h0);
        check("reset counters", {frame_cnt, trunc_cnt, underrun_cnt}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Short 3-DW TLP with latency and exact byte checks.
        make_tlp(2, 8'h0F);
        model_frame();
        push_tlp();
        step();
        check("latency cycle 1 tvalid", m_axis.tvalid, 64'h0);
        step();
        check("latency cycle 2 tvalid", m_axis.tvalid, 64'h1);
        run_frames("short tlp");
        check("short tlp beats", got.size(), 64'd8);
        if (got.size() == 8) begin
            check("dst bytes", got[0].data[47:0], 48'h01_00_00_00_00_02);
            check("ethertype bytes", got[1].data[47:32], 16'hB588);
            check("beat3 keep", got[3].keep, 8'hFF);
            check("beat3 upper zero", got[3].data[63:32], 64'h0);
            check("pad beats zero",
                  got[4].data | got[5].data | got[6].data, 64'h0);
            check("beat7 keep/last", {got[7].keep, got[7].last},
                  {8'h0F, 1'b1});
        end
        check_frames("short tlp");
        check("short frame_cnt", frame_cnt, exp_frames);
        clear_frames();

        for (int v = 0; v < 10; v++) begin
            make_tlp(vt[v].nw, vt[v].lk);
            model_frame();
            push_tlp();
            run_frames($sformatf("vec%0d", v));
            check($sformatf("vec%0d beats", v), got.size(), vt[v].nbeats);
            if (got.size() > 0)
                check($sformatf("vec%0d last beat", v),
                      {got[got.size()-1].keep, got[got.size()-1].last,
                       got[got.size()-1].user},
                      {vt[v].keep, 1'b1, vt[v].user});
            check_frames($sformatf("vec%0d", v));
            check($sformatf("vec%0d frame_cnt", v), frame_cnt, exp_frames);
            check($sformatf("vec%0d trunc_cnt", v), trunc_cnt, exp_trunc);
            clear_frames();
        end

        // FIFO runs dry for exactly 5 cycles mid-payload.
        make_tlp(12, 8'hFF);
        model_frame();
        ur0 = underrun_cnt;
        for (int i = 0; i < 5; i++) fifo.push_back(tlp[i]);
        fifo_sync();
        cyc = 0;
        while (fifo.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        check("underrun pre-drain", fifo.size(), 64'h0);
        repeat (5) step();
        for (int i = 5; i < 12; i++) fifo.push_back(tlp[i]);
        fifo_sync();
        run_frames("underrun");
        check("underrun_cnt delta", underrun_cnt - ur0, 64'd5);
        check_frames("underrun");
        clear_frames();

        // Random lengths under 50% tready, queued back to back.
        rand_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            lk = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h0F;
            make_tlp($urandom_range(1, 20), lk);
            model_frame();
            push_tlp();
        end
        run_frames("random");
        check_frames("random");
        check("random frame_cnt", frame_cnt, exp_frames);
        clear_frames();
        rand_ready = 1'b0;
        tready = 1'b1;

        // Reset in the middle of a frame.
        make_tlp(12, 8'hFF);
        push_tlp();
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset tdata", m_axis.tdata, 64'h0);
        check("mid reset ctrl", {m_axis.tvalid, m_axis.tkeep, m_axis.tlast,
                                 m_axis.tuser, rd_en}, 64'h0);
        check("mid reset counters",
              {frame_cnt, trunc_cnt, underrun_cnt}, 64'h0);
        fifo.delete();
        fifo_sync();
        repeat (3) @(posedge clk);
        #1;
        clear_frames();
        exp_seq = 16'h0;
        exp_frames = 0;
        exp_trunc = 0;
        rst_n = 1'b1;
        make_tlp(3, 8'h0F);
        model_frame();
        push_tlp();
        run_frames("post reset");
        check_frames("post reset");
        check("post reset frame_cnt", frame_cnt, 64'd1);
        clear_frames();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
